// File: rtl/dma_arbiter.sv
// Round-robin DMA arbiter for three requesters (layer fetch, image load, result write).
// Optional watchdog enabled by defining DMA_ARB_WATCHDOG_EN.
module dma_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] addr2,
  input  logic [4:0]  len0,
  input  logic [4:0]  len1,
  input  logic [4:0]  len2,
  input  logic        dmaDone,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        dmaEnable,
  output logic        loadEnable,
  output logic        writeEnable,
  output logic [15:0] dmaAddress,
  output logic [4:0]  dmaLength,
  output logic        busy,
  output logic        timeoutErr,
  output logic [1:0]  state_o
);

  // Handshake: req is level-held by a requester until done pulses for it;
  // dmaEnable stays high until the DMA engine answers with dmaDone.

  localparam logic [4:0] BLOCK_SIZE = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  win_q, win_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  done_q, done_d;
  logic        en_q, en_d;
  logic        ld_q, ld_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  len_q, len_d;
  logic        wd_expire;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] v);
    return 3'b001 << v;
  endfunction

  logic [1:0]  cand0, cand1, cand2, pick;
  logic [15:0] sel_addr;
  logic [4:0]  sel_len, len_clamp;

  // Search order starts at the round-robin pointer and wraps 2 -> 0.
  always_comb begin
    cand0 = rr_q;
    cand1 = inc3(rr_q);
    cand2 = inc3(cand1);
    if (req[cand0])      pick = cand0;
    else if (req[cand1]) pick = cand1;
    else                 pick = cand2;
  end

  always_comb begin
    sel_addr = addr0;
    sel_len  = len0;
    case (pick)
      2'd1: begin sel_addr = addr1; sel_len = len1; end
      2'd2: begin sel_addr = addr2; sel_len = len2; end
      default: begin sel_addr = addr0; sel_len = len0; end
    endcase
    len_clamp = (sel_len > BLOCK_SIZE) ? BLOCK_SIZE : sel_len;
  end

`ifdef DMA_ARB_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;
  logic       to_q, to_d;
  // Fires on the BUSY cycle that takes the counter to 255.
  assign wd_expire  = (wd_q == 8'd254);
  assign timeoutErr = to_q;
`else
  assign wd_expire  = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= 16'd0;
      len_q   <= 5'd0;
`ifdef DMA_ARB_WATCHDOG_EN
      wd_q    <= 8'd0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
`ifdef DMA_ARB_WATCHDOG_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = (len_clamp == 5'd0) ? S_RELEASE : S_BUSY;
      end
      S_BUSY: begin
        if (dmaDone || wd_expire) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d   = rr_q;
    win_d  = win_q;
    gnt_d  = gnt_q;
    done_d = 3'b000;
    en_d   = en_q;
    ld_d   = ld_q;
    wr_d   = wr_q;
    busy_d = busy_q;
    addr_d = addr_q;
    len_d  = len_q;
`ifdef DMA_ARB_WATCHDOG_EN
    wd_d   = wd_q;
    to_d   = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d  = pick;
          addr_d = sel_addr;
          len_d  = len_clamp;
          // Zero-length bursts complete immediately without touching the DMA.
          if (len_clamp == 5'd0) begin
            done_d = onehot(pick);
          end else begin
            gnt_d  = onehot(pick);
            en_d   = 1'b1;
            ld_d   = (pick != 2'd2);
            wr_d   = (pick == 2'd2);
            busy_d = 1'b1;
`ifdef DMA_ARB_WATCHDOG_EN
            wd_d   = 8'd0;
`endif
          end
        end
      end
      S_BUSY: begin
        if (dmaDone || wd_expire) begin
          gnt_d  = 3'b000;
          en_d   = 1'b0;
          ld_d   = 1'b0;
          wr_d   = 1'b0;
          busy_d = 1'b0;
          done_d = onehot(win_q);
`ifdef DMA_ARB_WATCHDOG_EN
          to_d   = to_q | (wd_expire & ~dmaDone);
`endif
        end else begin
`ifdef DMA_ARB_WATCHDOG_EN
          wd_d   = wd_q + 8'd1;
`endif
        end
      end
      S_RELEASE: rr_d = inc3(win_q);
      default: ;
    endcase
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign dmaEnable   = en_q;
  assign loadEnable  = ld_q;
  assign writeEnable = wr_q;
  assign busy        = busy_q;
  assign dmaAddress  = addr_q;
  assign dmaLength   = len_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Randomized self-checking bench for dma_arbiter using a transaction-level reference model.
// Covers the DMA_ARB_WATCHDOG_EN build when that macro is defined.
module tb_dma_arbiter;
  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] addr0, addr1, addr2;
  logic [4:0]  len0, len1, len2;
  logic        dmaDone;
  logic [2:0]  gnt, done;
  logic        dmaEnable, loadEnable, writeEnable;
  logic [15:0] dmaAddress;
  logic [4:0]  dmaLength;
  logic        busy, timeoutErr;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;
  int rr_m     = 0;
  logic exp_to = 1'b0;

  dma_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .len0(len0), .len1(len1), .len2(len2),
    .dmaDone(dmaDone), .gnt(gnt), .done(done),
    .dmaEnable(dmaEnable), .loadEnable(loadEnable), .writeEnable(writeEnable),
    .dmaAddress(dmaAddress), .dmaLength(dmaLength),
    .busy(busy), .timeoutErr(timeoutErr), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_m(input logic [2:0] r, input int rr);
    for (int k = 0; k < 3; k++)
      if (r[(rr + k) % 3]) return (rr + k) % 3;
    return -1;
  endfunction

  task automatic randomize_inputs();
    addr0 = 16'($urandom); addr1 = 16'($urandom); addr2 = 16'($urandom);
    len0 = 5'($urandom_range(0, 31));
    len1 = 5'($urandom_range(0, 31));
    len2 = 5'($urandom_range(0, 31));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_en"}, 32'(dmaEnable), 0);
    check({tag, "_ld"}, 32'(loadEnable), 0);
    check({tag, "_wr"}, 32'(writeEnable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle_outputs(tag);
    check({tag, "_addr"}, 32'(dmaAddress), 0);
    check({tag, "_len"}, 32'(dmaLength), 0);
    check({tag, "_to"}, 32'(timeoutErr), 0);
  endtask

  // Called at a negedge while the arbiter is idle; returns at a negedge back in idle.
  task automatic run_txn(input logic [2:0] r, input int dly, input bit keep, input bit scramble);
    logic [15:0] a [3];
    logic [4:0]  l [3];
    logic [2:0]  oh;
    int w, el;
    a[0] = addr0; a[1] = addr1; a[2] = addr2;
    l[0] = len0;  l[1] = len1;  l[2] = len2;
    req = r;
    w  = pick_m(r, rr_m);
    el = (l[w] > 25) ? 25 : int'(l[w]);
    oh = 3'b001 << w;
    @(posedge clk); @(negedge clk);
    check("lat_addr", 32'(dmaAddress), 32'(a[w]));
    check("lat_len", 32'(dmaLength), 32'(el));
    if (el == 0) begin
      check("z_done", 32'(done), 32'(oh));
      check("z_gnt", 32'(gnt), 0);
      check("z_en", 32'(dmaEnable), 0);
      check("z_busy", 32'(busy), 0);
      req = keep ? r : 3'b000;
    end else begin
      check("b_gnt", 32'(gnt), 32'(oh));
      check("b_en", 32'(dmaEnable), 1);
      check("b_ld", 32'(loadEnable), 32'(w != 2));
      check("b_wr", 32'(writeEnable), 32'(w == 2));
      check("b_busy", 32'(busy), 1);
      check("b_done", 32'(done), 0);
      for (int i = 0; i < dly; i++) begin
        if (scramble) begin
          randomize_inputs();
          req = 3'($urandom_range(0, 7));
        end
        dmaDone = 1'b0;
        @(posedge clk); @(negedge clk);
        check("hold_gnt", 32'(gnt), 32'(oh));
        check("hold_en", 32'(dmaEnable), 1);
        check("hold_addr", 32'(dmaAddress), 32'(a[w]));
        check("hold_len", 32'(dmaLength), 32'(el));
        check("hold_done", 32'(done), 0);
      end
      dmaDone = 1'b1;
      @(posedge clk); @(negedge clk);
      check("d_done", 32'(done), 32'(oh));
      check("d_gnt", 32'(gnt), 0);
      check("d_en", 32'(dmaEnable), 0);
      check("d_ld", 32'(loadEnable), 0);
      check("d_wr", 32'(writeEnable), 0);
      check("d_busy", 32'(busy), 0);
      check("d_to", 32'(timeoutErr), 32'(exp_to));
      req = keep ? r : 3'b000;
    end
    rr_m = (w + 1) % 3;
    @(posedge clk); @(negedge clk);
    dmaDone = 1'b0;
    check("rel_done", 32'(done), 0);
    check("rel_gnt", 32'(gnt), 0);
    check("rel_en", 32'(dmaEnable), 0);
  endtask

  initial begin
    reset = 1'b0; req = 3'b000; dmaDone = 1'b0;
    addr0 = 16'd0; addr1 = 16'd0; addr2 = 16'd0;
    len0 = 5'd0; len1 = 5'd0; len2 = 5'd0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Held 111: grant order 0,1,2,0 from a reset pointer.
    randomize_inputs();
    len0 = 5'd4; len1 = 5'd7; len2 = 5'd2;
    for (int i = 0; i < 4; i++) run_txn(3'b111, 1, 1'b1, 1'b0);
    req = 3'b000;
    @(negedge clk);

    // Single fetch request, dmaDone four cycles after dmaEnable.
    addr0 = 16'h0100; len0 = 5'd3;
    run_txn(3'b001, 3, 1'b0, 1'b0);

    // Clamp above BLOCK_SIZE and zero-length skip.
    len1 = 5'd31;
    run_txn(3'b010, 2, 1'b0, 1'b0);
    len2 = 5'd0;
    run_txn(3'b100, 0, 1'b0, 1'b0);

    // dmaDone with no request outstanding is ignored.
    dmaDone = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle_dd");
    dmaDone = 1'b0;

`ifdef DMA_ARB_WATCHDOG_EN
    req = 3'b001; len0 = 5'd5; addr0 = 16'h1234;
    @(posedge clk); @(negedge clk);
    check("wd_busy0", 32'(busy), 1);
    for (int i = 0; i < 254; i++) begin
      @(posedge clk); @(negedge clk);
      check("wd_busy", 32'(busy), 1);
      check("wd_to0", 32'(timeoutErr), 0);
    end
    @(posedge clk); @(negedge clk);
    exp_to = 1'b1;
    check("wd_done", 32'(done), 32'b001);
    check("wd_en", 32'(dmaEnable), 0);
    check("wd_to", 32'(timeoutErr), 1);
    req = 3'b000;
    rr_m = 1;
    @(posedge clk); @(negedge clk);
    check("wd_sticky", 32'(timeoutErr), 1);
`else
    // Without the watchdog a stalled DMA holds the grant indefinitely.
    len0 = 5'd5;
    rr_m = pick_m(3'b001, rr_m);
    run_txn(3'b001, 300, 1'b0, 1'b0);
    check("no_wd_to", 32'(timeoutErr), 0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [2:0] r;
      randomize_inputs();
      if ($urandom_range(0, 7) == 0) len1 = 5'd0;
      r = 3'($urandom_range(1, 7));
      run_txn(r, $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b1);
      req = 3'b000;
      @(negedge clk);
    end

    // Reset in the middle of a transaction abandons it.
    randomize_inputs();
    len1 = 5'd9; len2 = 5'd9; len0 = 5'd9;
    req = 3'b110;
    @(posedge clk); @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    req = 3'b000;
    @(posedge clk); @(negedge clk);
    check("mid_rst_done", 32'(done), 0);
    reset = 1'b1;
    rr_m = 0;
    exp_to = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_rst");
    len0 = 5'd6;
    run_txn(3'b111, 1, 1'b0, 1'b0);
    check("after_rst_rr", 32'(rr_m), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
